// File: rtl/vga_sync_gen.sv
// VGA timing generator: horizontal and vertical counters, each with an
// ACTIVE/FRONT/SYNC/BACK state machine. All outputs are registered from the
// pre-advance counter/state values, so they appear one pixel_ce edge late
// and stay mutually aligned. Every porch/sync region is assumed to be at
// least one count long.
module vga_sync_gen #(
  parameter logic [11:0] h_disp   = 12'd640,
  parameter logic [11:0] h_front  = 12'd16,
  parameter logic [11:0] h_sync   = 12'd96,
  parameter logic [11:0] h_back   = 12'd48,
  parameter logic [11:0] v_disp   = 12'd480,
  parameter logic [11:0] v_front  = 12'd10,
  parameter logic [11:0] v_sync   = 12'd2,
  parameter logic [11:0] v_back   = 12'd33,
  parameter logic        sync_pol = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_ce,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        display_enable,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        line_start,
  output logic        frame_start
);

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_t;

  // Totals may be exactly 4096, so they are formed in int and only the
  // last-count values (which always fit) are kept as 12-bit constants.
  localparam int H_TOTAL_I = int'(h_disp) + int'(h_front) + int'(h_sync) + int'(h_back);
  localparam int V_TOTAL_I = int'(v_disp) + int'(v_front) + int'(v_sync) + int'(v_back);

  localparam logic [11:0] H_ACT_LAST = 12'(int'(h_disp) - 1);
  localparam logic [11:0] H_FP_LAST  = 12'(int'(h_disp) + int'(h_front) - 1);
  localparam logic [11:0] H_SY_LAST  = 12'(int'(h_disp) + int'(h_front) + int'(h_sync) - 1);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL_I - 1);

  localparam logic [11:0] V_ACT_LAST = 12'(int'(v_disp) - 1);
  localparam logic [11:0] V_FP_LAST  = 12'(int'(v_disp) + int'(v_front) - 1);
  localparam logic [11:0] V_SY_LAST  = 12'(int'(v_disp) + int'(v_front) + int'(v_sync) - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL_I - 1);

  logic [11:0] h_cnt_reg, h_cnt_next;
  logic [11:0] v_cnt_reg, v_cnt_next;
  axis_state_t h_state_reg, h_state_next;
  axis_state_t v_state_reg, v_state_next;
  logic        h_wrap, v_wrap;

  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);

  // Counter advance: h wraps at its last count, v steps only on an h wrap.
  always_comb begin
    h_cnt_next = h_wrap ? 12'd0 : h_cnt_reg + 12'd1;
    v_cnt_next = v_cnt_reg;
    if (h_wrap) begin
      v_cnt_next = v_wrap ? 12'd0 : v_cnt_reg + 12'd1;
    end
  end

  // Horizontal FSM: leave each region on its last pixel.
  always_comb begin
    h_state_next = h_state_reg;
    case (h_state_reg)
      ACTIVE:  if (h_cnt_reg == H_ACT_LAST) h_state_next = FRONT;
      FRONT:   if (h_cnt_reg == H_FP_LAST)  h_state_next = SYNC;
      SYNC:    if (h_cnt_reg == H_SY_LAST)  h_state_next = BACK;
      BACK:    if (h_cnt_reg == H_LAST)     h_state_next = ACTIVE;
      default: h_state_next = ACTIVE;
    endcase
  end

  // Vertical FSM: same walk, but only evaluated at the end of a line.
  always_comb begin
    v_state_next = v_state_reg;
    if (h_wrap) begin
      case (v_state_reg)
        ACTIVE:  if (v_cnt_reg == V_ACT_LAST) v_state_next = FRONT;
        FRONT:   if (v_cnt_reg == V_FP_LAST)  v_state_next = SYNC;
        SYNC:    if (v_cnt_reg == V_SY_LAST)  v_state_next = BACK;
        BACK:    if (v_cnt_reg == V_LAST)     v_state_next = ACTIVE;
        default: v_state_next = ACTIVE;
      endcase
    end
  end

  // State, counters and registered output decode; everything holds while
  // pixel_ce is low, which also stretches the pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_reg      <= 12'd0;
      v_cnt_reg      <= 12'd0;
      h_state_reg    <= ACTIVE;
      v_state_reg    <= ACTIVE;
      pixel_x        <= 12'd0;
      pixel_y        <= 12'd0;
      display_enable <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      o_hsync        <= ~sync_pol;
      o_vsync        <= ~sync_pol;
    end else if (pixel_ce) begin
      h_cnt_reg      <= h_cnt_next;
      v_cnt_reg      <= v_cnt_next;
      h_state_reg    <= h_state_next;
      v_state_reg    <= v_state_next;
      pixel_x        <= h_cnt_reg;
      pixel_y        <= v_cnt_reg;
      display_enable <= (h_state_reg == ACTIVE) && (v_state_reg == ACTIVE);
      line_start     <= (h_cnt_reg == 12'd0);
      frame_start    <= (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
      o_hsync        <= (h_state_reg == SYNC) ? sync_pol : ~sync_pol;
      o_vsync        <= (v_state_reg == SYNC) ? sync_pol : ~sync_pol;
    end
  end

endmodule
